// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus bundle for the four-digit multiplexed seven-segment scan controller.
//
// Load handshake: the producer raises load_valid with load_data stable; a
// transfer happens on every rising clock edge where load_valid and
// load_ready are both 1. load_ready depends only on registered state, never
// on load_valid, so the producer may wait for it without a combinational
// loop. While load_ready is 0 the offered data is ignored and may change.
interface seven_seg_scan_ctrl_if;
    logic        enable;      // 1 = digits may light
    logic        blank_lz;    // 1 = suppress leading-zero digits
    logic        load_valid;  // new display value offered
    logic [15:0] load_data;   // four hex nibbles, [3:0] = digit 0
    logic        load_ready;  // pending buffer empty
    logic [3:0]  nibble;      // nibble of the current digit
    logic [3:0]  digit_en;    // one-hot digit enable, all-zero = dark
    logic        frame_done;  // pulse on the last clock of digit 3's slot
    logic        scan_dbg;    // 1 = controller is in the SCAN mode

    // Producer / observer side.
    modport master (
        output enable,
        output blank_lz,
        output load_valid,
        output load_data,
        input  load_ready,
        input  nibble,
        input  digit_en,
        input  frame_done,
        input  scan_dbg
    );

    // Controller side.
    modport slave (
        input  enable,
        input  blank_lz,
        input  load_valid,
        input  load_data,
        output load_ready,
        output nibble,
        output digit_en,
        output frame_done,
        output scan_dbg
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller. Each digit gets a
// slot of CLKS_PER_DIGIT clocks; the first DEAD_CLKS clocks of every slot
// keep all digits dark to avoid ghosting. A new value is double-buffered in
// PENDING and only promoted to ACTIVE on a frame boundary, so a displayed
// frame is never torn.
module seven_seg_scan_ctrl #(
    parameter int CLKS_PER_DIGIT = 50000,  // 2..65535
    parameter int DEAD_CLKS      = 500     // 0..CLKS_PER_DIGIT-1
) (
    input  logic                  clk,
    input  logic                  rst,
    seven_seg_scan_ctrl_if.slave  bus
);

    typedef enum logic {
        BLANKED = 1'b0,
        SCAN    = 1'b1
    } mode_t;

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_DIGIT - 1);
    localparam logic [15:0] CNT_DEAD = 16'(DEAD_CLKS);

    mode_t       mode_q, mode_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] active_q, active_d;
    logic [15:0] pending_q, pending_d;
    logic        pend_full_q, pend_full_d;

    logic        accept;
    logic        slot_end;
    logic        frame_end;
    logic        past_dead;
    logic [3:0]  suppress;

    assign accept    = bus.load_valid & ~pend_full_q;
    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = (mode_q == SCAN) && slot_end && (idx_q == 2'd3);

    // Dead-time window: with no dead time every clock of the slot may light.
    if (DEAD_CLKS == 0) begin : g_no_dead
        assign past_dead = 1'b1;
    end else begin : g_dead
        assign past_dead = (cnt_q >= CNT_DEAD);
    end

    // State register; reset discards both display buffers immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= BLANKED;
            cnt_q       <= '0;
            idx_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Next-state: slot timing, digit advance, load buffering and promotion.
    always_comb begin
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        case (mode_q)
            BLANKED: begin
                // Nothing on screen yet: the first value goes straight to
                // ACTIVE and scanning starts from digit 0, slot clock 0.
                cnt_d = '0;
                idx_d = '0;
                if (accept) begin
                    active_d = bus.load_data;
                    mode_d   = SCAN;
                end
            end
            SCAN: begin
                if (slot_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                // Promotion only uses a buffer that was full before this
                // edge; while full, accept is 0, so the two never collide.
                if (frame_end && pend_full_q) begin
                    active_d    = pending_q;
                    pend_full_d = 1'b0;
                end
                if (accept) begin
                    pending_d   = bus.load_data;
                    pend_full_d = 1'b1;
                end
            end
            default: begin
                mode_d = BLANKED;
                cnt_d  = '0;
                idx_d  = '0;
            end
        endcase
    end

    // Leading-zero suppression from ACTIVE and the live blank_lz input.
    always_comb begin
        suppress    = 4'b0000;
        suppress[1] = bus.blank_lz & ~(|active_q[15:4]);
        suppress[2] = bus.blank_lz & ~(|active_q[15:8]);
        suppress[3] = bus.blank_lz & ~(|active_q[15:12]);
    end

    // Output decode from registered state plus enable / blank_lz only.
    always_comb begin
        bus.load_ready = ~pend_full_q;
        bus.frame_done = frame_end;
        bus.scan_dbg   = (mode_q == SCAN);
        bus.nibble     = 4'h0;
        bus.digit_en   = 4'b0000;
        if (mode_q == SCAN) begin
            bus.nibble = active_q[{idx_q, 2'b00} +: 4];
            if (bus.enable && past_dead && !suppress[idx_q]) begin
                bus.digit_en = 4'b0001 << idx_q;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with CLKS_PER_DIGIT = 4, DEAD_CLKS = 1.
// Every clock the stimulus drives inputs just after the rising edge and
// pushes the hand-derived expected output word; a monitor on the falling
// edge pops and compares. Word = {scan, load_ready, nibble, digit_en, frame_done}.
module tb_seven_seg_scan_ctrl;

    localparam int CPD  = 4;
    localparam int DEAD = 1;
    localparam logic [10:0] RST_EXP = {1'b0, 1'b1, 4'h0, 4'b0000, 1'b0};

    logic clk;
    logic rst;
    logic blz_v;

    seven_seg_scan_ctrl_if bus ();

    seven_seg_scan_ctrl #(
        .CLKS_PER_DIGIT (CPD),
        .DEAD_CLKS      (DEAD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard state.
    logic [10:0] exp_q[$];
    string       tag_q[$];
    int          vectors;
    int          miscompares;
    logic [10:0] mon_exp;
    logic [10:0] mon_act;
    string       mon_tag;

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: run did not reach its end, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // Monitor: outputs are stable mid-cycle, compare against the queue head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {bus.scan_dbg, bus.load_ready, bus.nibble, bus.digit_en, bus.frame_done};
            vectors++;
            if (mon_act !== mon_exp) begin
                miscompares++;
                $display("FAIL %s: got scan=%b rdy=%b nib=%h en=%b fd=%b, want scan=%b rdy=%b nib=%h en=%b fd=%b",
                         mon_tag, mon_act[10], mon_act[9], mon_act[8:5], mon_act[4:1], mon_act[0],
                         mon_exp[10], mon_exp[9], mon_exp[8:5], mon_exp[4:1], mon_exp[0]);
            end
        end
    end

    // One clock of stimulus plus its expected response.
    task automatic cyc(input logic r, input logic lv, input logic [15:0] ld,
                       input logic en, input logic blz, input logic [10:0] exp,
                       input string tag);
        @(posedge clk);
        #1;
        rst            = r;
        bus.load_valid = lv;
        bus.load_data  = ld;
        bus.enable     = en;
        bus.blank_lz   = blz;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // One digit slot of CPD clocks. rdy/lvm/ena are per-clock bit masks
    // (bit c = slot clock c); ld0 is offered on clock 0, ld on the others.
    task automatic slot(input int d, input logic [3:0] nib, input logic lit,
                        input logic [3:0] rdy, input logic [3:0] lvm,
                        input logic [15:0] ld0, input logic [15:0] ld,
                        input logic [3:0] ena, input string fr);
        for (int c = 0; c < CPD; c++) begin
            logic [3:0] en_exp;
            logic       fd_exp;
            en_exp = 4'b0000;
            if (lit && ena[c] && (c >= DEAD)) en_exp[d] = 1'b1;
            fd_exp = (d == 3) && (c == CPD - 1);
            cyc(1'b0, lvm[c], (c == 0) ? ld0 : ld, ena[c], blz_v,
                {1'b1, rdy[c], nib, en_exp, fd_exp},
                $sformatf("%s d%0d c%0d", fr, d, c));
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        blz_v          = 1'b0;
        rst            = 1'b1;
        bus.enable     = 1'b1;
        bus.blank_lz   = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 16'h0000;

        // Reset and idle BLANKED, then the first load goes straight to ACTIVE.
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, RST_EXP, "rst0");
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, RST_EXP, "rst1");
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, RST_EXP, "idle blanked");
        cyc(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, RST_EXP, "load in blanked");

        // Frame A: 0x1234 shown as 4,3,2,1.
        slot(0, 4'h4, 1'b1, 4'hF, 4'h0, 16'h0, 16'h0, 4'hF, "A");
        slot(1, 4'h3, 1'b1, 4'hF, 4'h0, 16'h0, 16'h0, 4'hF, "A");
        slot(2, 4'h2, 1'b1, 4'hF, 4'h0, 16'h0, 16'h0, 4'hF, "A");
        slot(3, 4'h1, 1'b1, 4'hF, 4'h0, 16'h0, 16'h0, 4'hF, "A");

        // Frame B: 0xABCD loaded mid-frame, current frame is not torn.
        slot(0, 4'h4, 1'b1, 4'hF,    4'h0,    16'h0,    16'h0,    4'hF, "B");
        slot(1, 4'h3, 1'b1, 4'b0011, 4'b0010, 16'hABCD, 16'hABCD, 4'hF, "B");
        slot(2, 4'h2, 1'b1, 4'h0,    4'h0,    16'hABCD, 16'hABCD, 4'hF, "B");
        slot(3, 4'h1, 1'b1, 4'h0,    4'h0,    16'hABCD, 16'hABCD, 4'hF, "B");

        // Frame C: 0xABCD; enable low for 6 clocks; accept on the boundary clock.
        slot(0, 4'hD, 1'b1, 4'hF, 4'h0,    16'h0, 16'h0,    4'hF,    "C");
        slot(1, 4'hC, 1'b1, 4'hF, 4'h0,    16'h0, 16'h0,    4'b0011, "C");
        slot(2, 4'hB, 1'b1, 4'hF, 4'h0,    16'h0, 16'h0,    4'b0000, "C");
        slot(3, 4'hA, 1'b1, 4'hF, 4'b1000, 16'h0, 16'h0050, 4'hF,    "C");

        // Frame D: still 0xABCD, valid held high with junk that must be ignored.
        slot(0, 4'hD, 1'b1, 4'h0, 4'hF, 16'hEEEE, 16'hEEEE, 4'hF, "D");
        slot(1, 4'hC, 1'b1, 4'h0, 4'hF, 16'hEEEE, 16'hEEEE, 4'hF, "D");
        slot(2, 4'hB, 1'b1, 4'h0, 4'hF, 16'hEEEE, 16'hEEEE, 4'hF, "D");
        slot(3, 4'hA, 1'b1, 4'h0, 4'hF, 16'hEEEE, 16'hEEEE, 4'hF, "D");

        // Frame E: 0x0050 with leading-zero blanking; 0x0000 accepted at clock 0.
        blz_v = 1'b1;
        slot(0, 4'h0, 1'b1, 4'b0001, 4'hF, 16'h0000, 16'hEEEE, 4'hF, "E");
        slot(1, 4'h5, 1'b1, 4'h0,    4'hF, 16'hEEEE, 16'hEEEE, 4'hF, "E");
        slot(2, 4'h0, 1'b0, 4'h0,    4'hF, 16'hEEEE, 16'hEEEE, 4'hF, "E");
        slot(3, 4'h0, 1'b0, 4'h0,    4'hF, 16'hEEEE, 16'hEEEE, 4'hF, "E");

        // Frame F: 0x0000 with blanking, only digit 0 lights; 0x7777 accepted.
        slot(0, 4'h0, 1'b1, 4'b0001, 4'b0001, 16'h7777, 16'h7777, 4'hF, "F");
        slot(1, 4'h0, 1'b0, 4'h0,    4'h0,    16'h0,    16'h0,    4'hF, "F");
        slot(2, 4'h0, 1'b0, 4'h0,    4'h0,    16'h0,    16'h0,    4'hF, "F");
        slot(3, 4'h0, 1'b0, 4'h0,    4'h0,    16'h0,    16'h0,    4'hF, "F");

        // Frame G: 0x7777 without blanking; 0x4321 pending, then reset mid-slot.
        blz_v = 1'b0;
        slot(0, 4'h7, 1'b1, 4'b0011, 4'b0010, 16'h4321, 16'h4321, 4'hF, "G");
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, {1'b1, 1'b0, 4'h7, 4'b0000, 1'b0}, "G d1 c0");
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, {1'b1, 1'b0, 4'h7, 4'b0010, 1'b0}, "G d1 c1");
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, RST_EXP, "async rst mid-slot");
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, RST_EXP, "rst held");
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, RST_EXP, $sformatf("post-rst idle %0d", i));
        end

        // Frame H: fresh load after reset, 0x0900 with blanking; no stale pending.
        blz_v = 1'b1;
        cyc(1'b0, 1'b1, 16'h0900, 1'b1, 1'b1, RST_EXP, "H load");
        slot(0, 4'h0, 1'b1, 4'hF, 4'h0, 16'h0, 16'h0, 4'hF, "H");
        slot(1, 4'h0, 1'b1, 4'hF, 4'h0, 16'h0, 16'h0, 4'hF, "H");
        slot(2, 4'h9, 1'b1, 4'hF, 4'h0, 16'h0, 16'h0, 4'hF, "H");
        slot(3, 4'h0, 1'b0, 4'hF, 4'h0, 16'h0, 16'h0, 4'hF, "H");
        slot(0, 4'h0, 1'b1, 4'hF, 4'h0, 16'h0, 16'h0, 4'hF, "H2");

        // Drain the last expectation and report.
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_DIGIT, default 50000: clocks per digit slot; legal range 2..65535.
REQ-002 SHALL have parameter DEAD_CLKS, default 500: clocks at the start of each slot with all digits off (anti-ghosting); legal range 0..CLKS_PER_DIGIT-1.
REQ-003 i_CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 i_RST  in  1  asynchronous, active-high reset.
REQ-005 i_ENABLE  in  1  1 = digits may light; 0 = force o_DIGIT_EN to 0, scan timing continues.
REQ-006 i_BLANK_LZ  in  1  1 = suppress leading-zero digits.
REQ-007 i_LOAD_VALID  in  1  new 16-bit display value offered.
REQ-008 i_LOAD_DATA  in  16  four hex nibbles; [3:0] = digit 0 (least significant) ... [15:12] = digit 3.
REQ-009 o_LOAD_READY  out  1  1 = pending buffer empty, load can be accepted.
REQ-010 o_NIBBLE  out  4  nibble of the current digit, for the binary-to-7-segment decoder.
REQ-011 o_DIGIT_EN  out  4  one-hot digit enable, active-high, bit n = digit n; all-zero = dark.
REQ-012 o_FRAME_DONE  out  1  one-cycle pulse on the last clock of digit 3's slot.

Function
REQ-013 State: mode {BLANKED, SCAN}; slot counter CNT (0..CLKS_PER_DIGIT-1); digit index IDX (0..3); 16-bit ACTIVE; 16-bit PENDING; flag PEND_FULL.
REQ-014 Accept = i_LOAD_VALID & o_LOAD_READY at a rising edge; o_LOAD_READY = ~PEND_FULL, combinational from registers.
REQ-015 In BLANKED: CNT and IDX hold at 0; o_DIGIT_EN = 0; o_FRAME_DONE = 0; an accept loads ACTIVE directly, leaves PEND_FULL = 0, and enters SCAN with CNT = 0, IDX = 0.
REQ-016 In SCAN: an accept loads PENDING and sets PEND_FULL; i_LOAD_DATA is ignored while o_LOAD_READY = 0.
REQ-017 In SCAN: CNT increments every clock; at CLKS_PER_DIGIT-1 it wraps to 0 and IDX advances 0->1->2->3->0.
REQ-018 Frame boundary = SCAN & CNT = CLKS_PER_DIGIT-1 & IDX = 3; o_FRAME_DONE = 1 exactly in that cycle.
REQ-019 At a frame-boundary edge, if PEND_FULL was 1 before that edge, PENDING is copied to ACTIVE and PEND_FULL clears; ACTIVE never changes mid-frame.
REQ-020 An accept on the frame-boundary cycle itself (PEND_FULL = 0 before the edge) fills PENDING; that value is promoted at the next boundary.
REQ-021 o_NIBBLE = ACTIVE[4*IDX+3 : 4*IDX] in SCAN, and 0 in BLANKED.
REQ-022 o_DIGIT_EN = one-hot(IDX) only when all hold: SCAN, i_ENABLE = 1, CNT >= DEAD_CLKS, digit IDX not suppressed; otherwise 0.
REQ-023 Leading-zero suppression (i_BLANK_LZ = 1): digit n > 0 is suppressed if ACTIVE nibbles n..3 are all zero; digit 0 is never suppressed; with i_BLANK_LZ = 0 no digit is suppressed.
REQ-024 Suppression is evaluated from ACTIVE and the live i_BLANK_LZ each cycle.
REQ-025 i_ENABLE does not affect CNT, IDX, the handshake or o_FRAME_DONE.
REQ-026 Outputs SHALL be glitch-free decodes of registered state plus i_ENABLE/i_BLANK_LZ; no output depends on i_LOAD_*.

Reset
REQ-027 i_RST = 1 SHALL immediately force: mode BLANKED, CNT = 0, IDX = 0, ACTIVE = 0, PENDING = 0, PEND_FULL = 0.
REQ-028 During and after reset (until first accept): o_LOAD_READY = 1, o_NIBBLE = 0, o_DIGIT_EN = 0, o_FRAME_DONE = 0.
REQ-029 Reset asserted mid-frame or with PEND_FULL = 1 SHALL discard both ACTIVE and PENDING; no value survives reset.

Verification (CLKS_PER_DIGIT = 4, DEAD_CLKS = 1)
REQ-030 Reset, then load 0x1234 -> SCAN starts; per digit slot o_DIGIT_EN = 0 for 1 clock then one-hot for 3 clocks; o_NIBBLE sequence 4,3,2,1; o_FRAME_DONE pulses every 16 clocks.
REQ-031 Load 0xABCD mid-frame while showing 0x1234 -> o_LOAD_READY drops next cycle; digits 1..3 still show 3,2,1; 0xABCD appears from the next IDX = 0 slot; o_LOAD_READY returns to 1 after the boundary.
REQ-032 i_LOAD_VALID held high continuously -> exactly one accept per frame; the second offered value is promoted one frame after the first; intervening data is not latched.
REQ-033 i_BLANK_LZ = 1 with ACTIVE = 0x0050 -> digits 2 and 3 stay dark; digits 1 and 0 light with 5, 0. With ACTIVE = 0x0000 only digit 0 lights, showing 0.
REQ-034 i_ENABLE = 0 for 6 clocks mid-frame -> o_DIGIT_EN = 0 throughout; o_FRAME_DONE timing is unchanged.
REQ-035 Assert i_RST mid-slot with PEND_FULL = 1 -> all outputs reach reset values without a clock edge; after release no digit lights until a new load is accepted.
